gpr_issue: RTL

Operand-issue stage that drives the master side of both general-purpose register buses. It accepts decoded instructions from decode, reads two source operands through the read bus, and registers them for execute. A 32-entry busy scoreboard stalls read-after-write and write-after-write hazards. The stage also forwards writeback results onto the write bus and clears the matching busy bit.

---
 rtl/gpr_issue_if.sv | 26 ++
 rtl/gpr_issue.sv | 104 ++++++++++
 2 files changed

// File: rtl/gpr_issue_if.sv
// Master/slave views of the general-purpose register file buses.
// The read bus has two ports. The write bus uses an active-low write enable.
interface gpr_rd_bus_io #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr_0;
    logic [ADDR_W-1:0] addr_1;
    logic [DATA_W-1:0] data_0;
    logic [DATA_W-1:0] data_1;

    modport master (output addr_0, addr_1, input data_0, data_1);
    modport slave  (input addr_0, addr_1, output data_0, data_1);
endinterface

interface gpr_wr_bus_io #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              we_;

    modport master (output addr, data, we_);
    modport slave  (input addr, data, we_);
endinterface

// File: rtl/gpr_issue.sv
// Operand-issue stage. It reads two sources, registers them for execute, tracks
// in-flight destinations in a busy scoreboard and forwards writebacks to the file.
module gpr_issue #(
    parameter int GPR_NUM = 32,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_ra,
    input  logic [ADDR_W-1:0] in_rb,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic              in_dst_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op_a,
    output logic [DATA_W-1:0] out_op_b,
    output logic [ADDR_W-1:0] out_dst,
    output logic              out_dst_we,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    gpr_rd_bus_io.master      rd,
    gpr_wr_bus_io.master      wr,
    output logic              busy_any,
    output logic              wb_spurious
);
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        logic [ADDR_W-1:0] dst;
        logic              dst_we;
    } issue_reg_t;

    issue_reg_t         out_q, out_d;
    logic [GPR_NUM-1:0] busy_q, busy_d;
    logic               spurious_q, spurious_d;
    logic               clr_a, clr_b, clr_dst;
    logic               hazard, issue;

    assign rd.addr_0 = in_ra;
    assign rd.addr_1 = in_rb;
    assign wr.addr   = wb_addr;
    assign wr.data   = wb_data;
    assign wr.we_    = wb_valid ? ENABLE_ : DISABLE_;

    always_comb begin
        clr_a   = wb_valid && (wb_addr == in_ra);
        clr_b   = wb_valid && (wb_addr == in_rb);
        clr_dst = wb_valid && (wb_addr == in_dst);
        // A same-cycle writeback releases its waiter. The file bypass supplies the value.
        hazard  = (busy_q[in_ra] && !clr_a) ||
                  (busy_q[in_rb] && !clr_b) ||
                  (in_dst_we && busy_q[in_dst] && !clr_dst);
        in_ready = (!out_q.vld || out_ready) && !hazard;
        issue    = in_valid && in_ready;

        out_d = out_q;
        if (issue) begin
            out_d.vld    = 1'b1;
            out_d.op_a   = rd.data_0;
            out_d.op_b   = rd.data_1;
            out_d.dst    = in_dst;
            out_d.dst_we = in_dst_we;
        end else if (out_ready) begin
            out_d.vld = 1'b0;
        end

        // Clear first, then set, so a new producer wins over a retiring one.
        busy_d = busy_q;
        if (wb_valid)
            busy_d[wb_addr] = 1'b0;
        if (issue && in_dst_we)
            busy_d[in_dst] = 1'b1;

        spurious_d = spurious_q || (wb_valid && !busy_q[wb_addr]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            busy_q     <= '0;
            spurious_q <= 1'b0;
        end else begin
            out_q      <= out_d;
            busy_q     <= busy_d;
            spurious_q <= spurious_d;
        end
    end

    assign out_valid   = out_q.vld;
    assign out_op_a    = out_q.op_a;
    assign out_op_b    = out_q.op_b;
    assign out_dst     = out_q.dst;
    assign out_dst_we  = out_q.dst_we;
    assign busy_any    = |busy_q;
    assign wb_spurious = spurious_q;
endmodule
